// File: rtl/sequence_detector_110110.sv
// Serial pattern detector for the bit sequence 1-1-0-1-1-0 (first bit received
// is the pattern MSB). Moore machine: the match strobe is a flop that is set
// exactly when the state register enters S6. After a match the machine either
// keeps the trailing "110" as a head start (OVERLAP=1) or starts over (OVERLAP=0).
module sequence_detector_110110 #(
    parameter logic OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    // States are named for the prefix of 110110 matched so far.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // nothing matched
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "11"
        S3 = 3'd3,  // "110"
        S4 = 3'd4,  // "1101"
        S5 = 3'd5,  // "11011"
        S6 = 3'd6   // "110110", full match
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   dout_q;
    logic   dout_d;

    // Next-state logic: longest pattern prefix that is a suffix of the input seen so far.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0: begin
                if (din) state_d = S1;
                else     state_d = S0;
            end
            S1: begin
                if (din) state_d = S2;
                else     state_d = S0;
            end
            S2: begin
                // "111" still ends in "11"
                if (din) state_d = S2;
                else     state_d = S3;
            end
            S3: begin
                if (din) state_d = S4;
                else     state_d = S0;
            end
            S4: begin
                if (din) state_d = S5;
                else     state_d = S0;
            end
            S5: begin
                // "110111" still ends in "11"
                if (din) state_d = S2;
                else     state_d = S6;
            end
            S6: begin
                // With overlap the match's trailing "110" behaves like S3.
                if (din) begin
                    if (OVERLAP) state_d = S4;
                    else         state_d = S1;
                end else begin
                    state_d = S0;
                end
            end
            default: begin
                // Unused code 7 recovers to idle.
                state_d = S0;
            end
        endcase
    end

    // Strobe decode: the output flop mirrors (state_q == S6), so it depends on state only.
    always_comb begin
        dout_d = 1'b0;
        if (state_d == S6) dout_d = 1'b1;
        else               dout_d = 1'b0;
    end

    // State and strobe registers; reset clears both immediately, without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_sequence_detector_110110.sv
// Testbench for sequence_detector_110110: runs an overlapping and a
// non-overlapping instance side by side on the same stimulus. Expected strobes
// come from a sliding window of the last six bits since reset, plus a count of
// bits since the last accepted match for the non-overlapping variant.
module tb_sequence_detector_110110;

    logic clk;
    logic reset;
    logic din;
    logic dout_ov;
    logic dout_no;

    int errors;
    int checks;
    int pulses_ov;
    int pulses_no;

    // reference model state
    logic [5:0] hist;
    int         nbits;
    int         since_no;
    logic       exp_ov;
    logic       exp_no;

    localparam logic [5:0] PAT = 6'b110110;

    sequence_detector_110110 #(.OVERLAP(1'b1)) dut_ov (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout_ov)
    );

    sequence_detector_110110 #(.OVERLAP(1'b0)) dut_no (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        hist     = 6'b000000;
        nbits    = 0;
        since_no = 0;
        exp_ov   = 1'b0;
        exp_no   = 1'b0;
    endtask

    task automatic model_step(input logic b);
        hist     = {hist[4:0], b};
        nbits    = nbits + 1;
        since_no = since_no + 1;
        exp_ov   = (nbits >= 6) && (hist == PAT);
        exp_no   = (since_no >= 6) && (hist == PAT);
        if (exp_no) since_no = 0;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one bit (and reset level) at the falling edge, check after the rising edge.
    task automatic send_bit(input string tag, input logic b, input logic rst_v);
        @(negedge clk);
        reset = rst_v;
        din   = b;
        if (!rst_v) model_reset();
        @(posedge clk);
        #1;
        if (rst_v) model_step(b);
        check_bit({tag, "_ov"}, dout_ov, exp_ov);
        check_bit({tag, "_no"}, dout_no, exp_no);
        if (dout_ov === 1'b1) pulses_ov = pulses_ov + 1;
        if (dout_no === 1'b1) pulses_no = pulses_no + 1;
    endtask

    // Send n bits of v, MSB first, with reset released.
    task automatic send_vec(input string tag, input logic [31:0] v, input int n);
        logic [31:0] vv;
        vv = v;
        for (int i = n - 1; i >= 0; i--) send_bit(tag, vv[i], 1'b1);
    endtask

    task automatic clear_pulses();
        pulses_ov = 0;
        pulses_no = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_pulses();
        model_reset();
        reset = 1'b0;
        din   = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_state_ov", dout_ov, 1'b0);
        check_bit("rst_state_no", dout_no, 1'b0);

        // 1: pattern toggled while reset is held must be ignored
        clear_pulses();
        send_bit("t1_rst", 1'b1, 1'b0);
        send_bit("t1_rst", 1'b1, 1'b0);
        send_bit("t1_rst", 1'b0, 1'b0);
        send_bit("t1_rst", 1'b1, 1'b0);
        send_bit("t1_rst", 1'b1, 1'b0);
        send_bit("t1_rst", 1'b0, 1'b0);
        send_vec("t1_zero", 32'h0, 4);
        check_int("t1_pulses_ov", pulses_ov, 0);
        check_int("t1_pulses_no", pulses_no, 0);

        // 2: single match
        clear_pulses();
        send_vec("t2", 32'b110110, 6);
        send_vec("t2_tail", 32'h0, 4);
        check_int("t2_pulses_ov", pulses_ov, 1);
        check_int("t2_pulses_no", pulses_no, 1);

        // 3: overlapping pair
        clear_pulses();
        send_vec("t3", 32'b110110110, 9);
        send_vec("t3_tail", 32'h0, 4);
        check_int("t3_pulses_ov", pulses_ov, 2);
        check_int("t3_pulses_no", pulses_no, 1);

        // 4: near miss then match
        clear_pulses();
        send_vec("t4", 32'b1101110110, 10);
        send_vec("t4_tail", 32'h0, 4);
        check_int("t4_pulses_ov", pulses_ov, 1);
        check_int("t4_pulses_no", pulses_no, 1);

        // 5: run-in of ones, then all-zero and all-one streams
        clear_pulses();
        send_vec("t5", 32'b111110110, 9);
        send_vec("t5_tail", 32'h0, 4);
        check_int("t5_pulses_ov", pulses_ov, 1);
        check_int("t5_pulses_no", pulses_no, 1);
        clear_pulses();
        send_vec("t5_zeros", 32'h0, 20);
        send_vec("t5_ones", 32'hFFFFF, 20);
        send_vec("t5_flush", 32'h0, 2);
        check_int("t5_flat_ov", pulses_ov, 0);
        check_int("t5_flat_no", pulses_no, 0);

        // 6: asynchronous reset mid-sequence
        clear_pulses();
        send_vec("t6_part", 32'b11011, 5);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_bit("t6_async_ov", dout_ov, 1'b0);
        check_bit("t6_async_no", dout_no, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        send_bit("t6_after", 1'b0, 1'b1);
        check_int("t6_nopulse_ov", pulses_ov, 0);
        check_int("t6_nopulse_no", pulses_no, 0);
        send_vec("t6_full", 32'b110110, 6);
        check_bit("t6_high_ov", dout_ov, 1'b1);
        check_bit("t6_high_no", dout_no, 1'b1);
        check_int("t6_pulses_ov", pulses_ov, 1);
        check_int("t6_pulses_no", pulses_no, 1);
        // reset while the strobe is high must drop it without a clock edge
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_bit("t6_drop_ov", dout_ov, 1'b0);
        check_bit("t6_drop_no", dout_no, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        send_vec("t6_tail", 32'h0, 3);

        // randomized stream, biased toward the pattern, with rare resets
        for (int i = 0; i < 1200; i++) begin
            logic b;
            logic [5:0] pv;
            logic r;
            pv = PAT;
            if ($urandom_range(0, 3) != 0) b = pv[5 - (i % 6)];
            else                           b = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            send_bit("rand", b, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
